// File: rtl/hic_pkg.sv
// Shared constants for the HIC sequencer: HIC mode encodings, command opcodes
// and the sequencer FSM state type.
package hic_pkg;

  localparam logic [1:0] HIC_HOLD  = 2'b00;
  localparam logic [1:0] HIC_COUNT = 2'b01;
  localparam logic [1:0] HIC_SHIFT = 2'b10;
  localparam logic [1:0] HIC_LOAD  = 2'b11;

  // Opcodes map 1:1 onto HIC modes so RUN can drive the opcode straight out.
  localparam logic [1:0] OP_WAIT  = HIC_HOLD;
  localparam logic [1:0] OP_COUNT = HIC_COUNT;
  localparam logic [1:0] OP_SHIFT = HIC_SHIFT;
  localparam logic [1:0] OP_LOAD  = HIC_LOAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/hic_len_counter.sv
// Loadable down-counter timing the RUN phase; last is high while the count is 1,
// i.e. during the final cycle of a run.
module hic_len_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [LEN_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/hic_sequencer.sv
// Command-driven controller for one HIC register: takes a command over
// valid/ready, drives HIC mode/cin/pin for the run, then reports result and carries.
module hic_sequencer
  import hic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  input  logic             abort,
  input  logic [WIDTH-1:0] hic_fout,
  input  logic             hic_cout,
  output logic [1:0]       hic_min,
  output logic             hic_cin,
  output logic [WIDTH-1:0] hic_pin,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result,
  output logic [LEN_W-1:0] carry_cnt
);

  state_e           state_d, state_q;
  logic [1:0]       hic_min_d, hic_min_q;
  logic             hic_cin_d, hic_cin_q;
  logic [WIDTH-1:0] hic_pin_d, hic_pin_q;
  logic             cmd_ready_d, cmd_ready_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             aborted_d, aborted_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic [LEN_W-1:0] carry_cnt_d, carry_cnt_q;

  logic handshake;
  logic run_load;
  logic run_last;

  assign handshake = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
  assign run_load  = handshake && (cmd_op != OP_LOAD) && (cmd_len != '0);

  hic_len_counter #(.LEN_W(LEN_W)) u_len_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .load_val (cmd_len),
    .dec      (state_q == ST_RUN),
    .last     (run_last)
  );

  always_comb begin
    state_d     = state_q;
    hic_min_d   = hic_min_q;
    hic_cin_d   = hic_cin_q;
    hic_pin_d   = hic_pin_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    result_d    = result_q;
    carry_cnt_d = carry_cnt_q;

    case (state_q)
      ST_IDLE: begin
        hic_min_d = HIC_HOLD;
        if (handshake) begin
          hic_cin_d   = cmd_cin;
          carry_cnt_d = '0;
          if (cmd_op == OP_LOAD) begin
            state_d   = ST_LOAD;
            hic_min_d = HIC_LOAD;
            hic_pin_d = cmd_data;
          end else if (cmd_len != '0) begin
            state_d   = ST_RUN;
            hic_min_d = cmd_op;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        hic_min_d = HIC_HOLD;
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        if (hic_cout && (carry_cnt_q != '1)) begin
          carry_cnt_d = carry_cnt_q + LEN_W'(1);
        end
        // Abort takes priority even on the final run cycle.
        if (abort) begin
          state_d   = ST_IDLE;
          hic_min_d = HIC_HOLD;
          aborted_d = 1'b1;
        end else if (run_last) begin
          state_d   = ST_DONE;
          hic_min_d = HIC_HOLD;
        end
      end
      ST_DONE: begin
        hic_min_d = HIC_HOLD;
        done_d    = 1'b1;
        result_d  = hic_fout;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        hic_min_d = HIC_HOLD;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hic_min_q   <= HIC_HOLD;
      hic_cin_q   <= 1'b0;
      hic_pin_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      result_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hic_min_q   <= hic_min_d;
      hic_cin_q   <= hic_cin_d;
      hic_pin_q   <= hic_pin_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      result_q    <= result_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign hic_min   = hic_min_q;
  assign hic_cin   = hic_cin_q;
  assign hic_pin   = hic_pin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign result    = result_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_hic_sequencer.sv
// Directed bench for hic_sequencer driving a behavioural 8-bit HIC register
// (hold/count/shift-right/load) with hand-computed expected values.
module tb_hic_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic       cmd_cin;
  logic       abort;
  logic [7:0] hic_fout;
  logic       hic_cout;
  logic [1:0] hic_min;
  logic       hic_cin;
  logic [7:0] hic_pin;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] result;
  logic [7:0] carry_cnt;

  int checks = 0;
  int errors = 0;
  int lat;
  int active;

  hic_sequencer #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .cmd_cin   (cmd_cin),
    .abort     (abort),
    .hic_fout  (hic_fout),
    .hic_cout  (hic_cout),
    .hic_min   (hic_min),
    .hic_cin   (hic_cin),
    .hic_pin   (hic_pin),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .result    (result),
    .carry_cnt (carry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural HIC: carry-out flags the count step that wraps 0xFF to 0x00.
  always_ff @(posedge clk) begin
    if (rst) begin
      hic_fout <= 8'h00;
    end else begin
      case (hic_min)
        2'b01:   hic_fout <= hic_fout + {7'b0, hic_cin};
        2'b10:   hic_fout <= {hic_cin, hic_fout[7:1]};
        2'b11:   hic_fout <= hic_pin;
        default: hic_fout <= hic_fout;
      endcase
    end
  end
  assign hic_cout = (hic_min == 2'b01) && hic_cin && (hic_fout == 8'hFF);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command; returns at the sample point just after the handshake edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data,
                               input logic [7:0] len, input logic cin);
    checkOutput("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_cin   = cin;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~data;
    cmd_len   = 8'hFF;
    cmd_cin   = ~cin;
  endtask

  task automatic runCmd(input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] len, input logic cin);
    applyStimulus(op, data, len, cin);
    lat    = 0;
    active = 0;
    while (!done && lat < 600) begin
      if (hic_min != 2'b00) active++;
      step();
      lat++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_len   = 8'h00;
    cmd_cin   = 1'b0;
    abort     = 1'b0;
    step();
    step();
    checkOutput("rst_min",     {30'b0, hic_min},   32'd0);
    checkOutput("rst_cin",     {31'b0, hic_cin},   32'd0);
    checkOutput("rst_pin",     {24'b0, hic_pin},   32'd0);
    checkOutput("rst_busy",    {31'b0, busy},      32'd0);
    checkOutput("rst_done",    {31'b0, done},      32'd0);
    checkOutput("rst_aborted", {31'b0, aborted},   32'd0);
    checkOutput("rst_result",  {24'b0, result},    32'd0);
    checkOutput("rst_carry",   {24'b0, carry_cnt}, 32'd0);
    checkOutput("rst_ready",   {31'b0, cmd_ready}, 32'd1);
    rst = 1'b0;
    step();

    // LOAD 0xA6: one load cycle, done two edges after the handshake.
    applyStimulus(2'b11, 8'hA6, 8'd0, 1'b0);
    checkOutput("load_min",   {30'b0, hic_min},   32'h3);
    checkOutput("load_pin",   {24'b0, hic_pin},   32'hA6);
    checkOutput("load_busy",  {31'b0, busy},      32'd1);
    checkOutput("load_ready", {31'b0, cmd_ready}, 32'd0);
    step();
    checkOutput("load_min_after", {30'b0, hic_min}, 32'h0);
    checkOutput("load_done_early", {31'b0, done},   32'd0);
    step();
    checkOutput("load_done",   {31'b0, done},      32'd1);
    checkOutput("load_result", {24'b0, result},    32'hA6);
    checkOutput("load_carry",  {24'b0, carry_cnt}, 32'd0);
    checkOutput("load_ready_at_done", {31'b0, cmd_ready}, 32'd1);
    step();
    checkOutput("load_done_pulse", {31'b0, done},  32'd0);

    // COUNT len=5 from 0xA6.
    runCmd(2'b01, 8'h00, 8'd5, 1'b1);
    checkOutput("count5_latency", lat,               32'd6);
    checkOutput("count5_active",  active,            32'd5);
    checkOutput("count5_result",  {24'b0, result},   32'hAB);
    checkOutput("count5_carry",   {24'b0, carry_cnt}, 32'd0);
    step();

    // LOAD 0xFE then COUNT len=3 wraps once.
    runCmd(2'b11, 8'hFE, 8'd0, 1'b0);
    checkOutput("load_fe_latency", lat, 32'd2);
    step();
    runCmd(2'b01, 8'h00, 8'd3, 1'b1);
    checkOutput("count3_latency", lat,                32'd4);
    checkOutput("count3_result",  {24'b0, result},    32'h01);
    checkOutput("count3_carry",   {24'b0, carry_cnt}, 32'd1);
    step();

    // LOAD 0xA6 then SHIFT len=2 with cin=1: A6 -> D3 -> E9.
    runCmd(2'b11, 8'hA6, 8'd0, 1'b0);
    step();
    runCmd(2'b10, 8'h00, 8'd2, 1'b1);
    checkOutput("shift2_latency", lat,                32'd3);
    checkOutput("shift2_active",  active,             32'd2);
    checkOutput("shift2_result",  {24'b0, result},    32'hE9);
    checkOutput("shift2_carry",   {24'b0, carry_cnt}, 32'd0);
    step();

    // COUNT len=0 completes immediately without moving HIC.
    runCmd(2'b01, 8'h00, 8'd0, 1'b1);
    checkOutput("len0_latency", lat,             32'd1);
    checkOutput("len0_active",  active,          32'd0);
    checkOutput("len0_result",  {24'b0, result}, 32'hE9);
    step();

    // Abort a COUNT len=10 after three HIC updates; carry partial value kept.
    runCmd(2'b11, 8'hFE, 8'd0, 1'b0);
    step();
    applyStimulus(2'b01, 8'h00, 8'd10, 1'b1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_pulse",  {31'b0, aborted},   32'd1);
    checkOutput("abort_min",    {30'b0, hic_min},   32'd0);
    checkOutput("abort_busy",   {31'b0, busy},      32'd0);
    checkOutput("abort_done",   {31'b0, done},      32'd0);
    checkOutput("abort_fout",   {24'b0, hic_fout},  32'h01);
    checkOutput("abort_carry",  {24'b0, carry_cnt}, 32'd1);
    checkOutput("abort_result", {24'b0, result},    32'hFE);
    step();
    checkOutput("abort_pulse_end", {31'b0, aborted},   32'd0);
    checkOutput("abort_no_done",   {31'b0, done},      32'd0);
    checkOutput("abort_ready",     {31'b0, cmd_ready}, 32'd1);
    checkOutput("abort_fout_hold", {24'b0, hic_fout},  32'h01);

    // Abort coinciding with the final RUN cycle suppresses done.
    runCmd(2'b11, 8'h00, 8'd0, 1'b0);
    step();
    applyStimulus(2'b01, 8'h00, 8'd3, 1'b1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_last_pulse", {31'b0, aborted},  32'd1);
    checkOutput("abort_last_fout",  {24'b0, hic_fout}, 32'h03);
    step();
    checkOutput("abort_last_no_done", {31'b0, done},   32'd0);
    checkOutput("abort_last_result",  {24'b0, result}, 32'h00);
    step();

    // Reset in the middle of a run.
    runCmd(2'b11, 8'h20, 8'd0, 1'b0);
    step();
    applyStimulus(2'b01, 8'h00, 8'd10, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    checkOutput("midrst_min",     {30'b0, hic_min},   32'd0);
    checkOutput("midrst_cin",     {31'b0, hic_cin},   32'd0);
    checkOutput("midrst_pin",     {24'b0, hic_pin},   32'd0);
    checkOutput("midrst_busy",    {31'b0, busy},      32'd0);
    checkOutput("midrst_done",    {31'b0, done},      32'd0);
    checkOutput("midrst_aborted", {31'b0, aborted},   32'd0);
    checkOutput("midrst_result",  {24'b0, result},    32'd0);
    checkOutput("midrst_carry",   {24'b0, carry_cnt}, 32'd0);
    checkOutput("midrst_ready",   {31'b0, cmd_ready}, 32'd1);
    rst = 1'b0;
    step();
    checkOutput("post_rst_min",   {30'b0, hic_min},   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
